// File: rtl/data_cache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache.
// Optional read hit/miss counters are built only when DCACHE_STATS_EN is defined.
//
//  state | meaning
//  IDLE  | accept request; read hits complete combinationally this cycle
//  FETCH | read miss, mem_readM held until the memory word arrives
//  WRITE | single-cycle write-through to memory, update line on tag hit
module data_cache #(
  parameter int READ_WAIT = 3,
  parameter int LINES     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_readM,
  output logic        mem_writeM,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses
);

  localparam int         IDX_W   = $clog2(LINES);
  localparam int         TAG_W   = 16 - IDX_W;
  localparam logic [2:0] WAIT_TC = 3'(READ_WAIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]       state;
  logic [2:0]       wait_cnt;
  logic [15:0]      req_addr;
  logic [15:0]      req_wdata;
  logic [LINES-1:0] valid;
  logic [15:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];

  logic [IDX_W-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag, req_tag;
  logic             cpu_hit, req_hit, fill_done;

  assign cpu_idx   = cpu_address[IDX_W-1:0];
  assign cpu_tag   = cpu_address[15:IDX_W];
  assign req_idx   = req_addr[IDX_W-1:0];
  assign req_tag   = req_addr[15:IDX_W];
  assign cpu_hit   = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign req_hit   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_done = (state == FETCH) && (wait_cnt == WAIT_TC);

  always_comb begin
    cpu_ready   = 1'b0;
    cpu_rdata   = data_mem[cpu_idx];
    mem_readM   = 1'b0;
    mem_writeM  = 1'b0;
    mem_address = req_addr;
    mem_wdata   = req_wdata;
    case (state)
      IDLE: begin
        mem_address = cpu_address;
        mem_wdata   = cpu_wdata;
        cpu_ready   = cpu_read && !cpu_write && cpu_hit;
      end
      FETCH: begin
        mem_readM = 1'b1;
        if (fill_done) begin
          cpu_ready = 1'b1;
          cpu_rdata = mem_rdata;
        end
      end
      WRITE: begin
        mem_writeM = 1'b1;
        cpu_ready  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            state <= WRITE;
          end else if (cpu_read && !cpu_hit) begin
            state    <= FETCH;
            wait_cnt <= 3'd0;
          end
        end
        FETCH: begin
          if (fill_done) begin
            state          <= IDLE;
            valid[req_idx] <= 1'b1;
          end
          if (wait_cnt != 3'd7) wait_cnt <= wait_cnt + 3'd1;
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request is frozen on leaving IDLE; arrays carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      req_addr  <= cpu_address;
      req_wdata <= cpu_wdata;
    end
    if (!reset) begin
      if (fill_done) begin
        data_mem[req_idx] <= mem_rdata;
        tag_mem[req_idx]  <= req_tag;
      end else if (state == WRITE && req_hit) begin
        data_mem[req_idx] <= req_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hits_q, misses_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= 16'd0;
      misses_q <= 16'd0;
    end else if (state == IDLE && cpu_read && !cpu_write) begin
      if (cpu_hit) hits_q   <= hits_q + 16'd1;
      else         misses_q <= misses_q + 16'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 16'd0;
  assign stat_misses = 16'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a latency-accurate memory model feeds the DUT,
// a reference cache/memory model predicts hit/miss, latency and read data.
module tb_data_cache;

  localparam int READ_WAIT = 3;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_address = 16'd0, cpu_wdata = 16'd0;
  logic [15:0] cpu_rdata, mem_address, mem_wdata, mem_rdata;
  logic        cpu_ready, mem_readM, mem_writeM;
  logic [15:0] stat_hits, stat_misses;

  data_cache #(.READ_WAIT(READ_WAIT), .LINES(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  // memory seen by the DUT: word valid on the (READ_WAIT+1)-th mem_readM cycle
  logic [15:0] mem_model [65536];
  logic [15:0] exp_mem   [65536];
  int          rd_cnt = 0;

  always @(posedge clk) begin
    rd_cnt <= mem_readM ? rd_cnt + 1 : 0;
    if (mem_writeM) mem_model[mem_address] <= mem_wdata;
  end
  assign mem_rdata = (mem_readM && rd_cnt == READ_WAIT) ? mem_model[mem_address] : 16'hF01C;

  // reference cache state
  bit          mv [16];
  logic [11:0] mt [16];
  int          m_hits = 0, m_misses = 0;

  typedef struct { logic [15:0] data; int lat; } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [15:0] a);
    return mv[a[3:0]] && (mt[a[3:0]] == a[15:4]);
  endfunction

  task automatic do_read(input logic [15:0] a);
    int cyc, rcyc, wcyc;
    bit got, hit;
    exp_t e;
    hit = model_hit(a);
    e.data = exp_mem[a];
    e.lat  = hit ? 1 : READ_WAIT + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = a;
    cyc = 0; rcyc = 0; wcyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk); cyc++;
      if (mem_readM) rcyc++;
      if (mem_writeM) wcyc++;
      if (cpu_ready) got = 1;
    end
    chk("rd_done", 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      chk("rd_data", 32'(cpu_rdata), 32'(e.data));
      chk("rd_latency", 32'(cyc), 32'(e.lat));
    end
    chk("rd_mem_readM_cycles", 32'(rcyc), hit ? 32'd0 : 32'(READ_WAIT + 1));
    chk("rd_no_writeM", 32'(wcyc), 32'd0);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    if (hit) m_hits++;
    else begin
      m_misses++;
      mv[a[3:0]] = 1'b1;
      mt[a[3:0]] = a[15:4];
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit also_read);
    int cyc, rcyc, wcyc;
    bit got;
    logic [15:0] seen_d, seen_a;
    @(posedge clk); #1;
    cpu_write = 1'b1; cpu_read = also_read; cpu_address = a; cpu_wdata = d;
    cyc = 0; rcyc = 0; wcyc = 0; got = 0; seen_d = 16'h0; seen_a = 16'h0;
    while (!got && cyc < 40) begin
      @(negedge clk); cyc++;
      if (mem_readM) rcyc++;
      if (mem_writeM) begin wcyc++; seen_d = mem_wdata; seen_a = mem_address; end
      if (cpu_ready) got = 1;
    end
    chk("wr_done", 32'(got), 32'd1);
    chk("wr_latency", 32'(cyc), 32'd2);
    chk("wr_writeM_cycles", 32'(wcyc), 32'd1);
    chk("wr_mem_wdata", 32'(seen_d), 32'(d));
    chk("wr_mem_address", 32'(seen_a), 32'(a));
    chk("wr_no_readM", 32'(rcyc), 32'd0);
    @(posedge clk); #1;
    cpu_write = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    chk("wr_writeM_dropped", 32'(mem_writeM), 32'd0);
    exp_mem[a] = d;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_hits"},   32'(stat_hits),   STATS ? 32'(m_hits)   : 32'd0);
    chk({tag, "_misses"}, 32'(stat_misses), STATS ? 32'(m_misses) : 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] pool [6];
    for (int i = 0; i < 65536; i++) begin
      v = 16'(i) * 16'h9E37 ^ 16'h1111;
      mem_model[i] = v;
      exp_mem[i]   = v;
    end
    mem_model[16'h0023] = 16'h6000; exp_mem[16'h0023] = 16'h6000;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_mem_readM", 32'(mem_readM), 32'd0);
    chk("rst_mem_writeM", 32'(mem_writeM), 32'd0);
    chk_stats("rst");

    do_read(16'h0023);                 // cold miss
    chk_stats("first_miss");
    do_read(16'h0023);                 // hit right after fill
    chk_stats("first_hit");
    do_write(16'h0023, 16'hBEEF, 1'b0);
    do_read(16'h0023);
    do_write(16'h0040, 16'h1234, 1'b0); // no allocate
    do_read(16'h0040);
    do_read(16'h0013);
    do_read(16'h0003);
    do_read(16'h0013);                 // evicted by 0x0003
    do_write(16'h0013, 16'h7777, 1'b1); // read+write together acts as a write
    do_read(16'h0013);
    chk_stats("mid");

    // reset during the second FETCH cycle abandons the fill
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 16'h0055;
    @(negedge clk);
    chk("abort_idle_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    chk("abort_f1_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_f2_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(cpu_ready), 32'd0);
    chk("abort_readM_after", 32'(mem_readM), 32'd0);
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_hits = 0; m_misses = 0;
    chk_stats("abort");
    do_read(16'h0055);                 // must miss again
    do_read(16'h0023);                 // everything invalid after reset

    pool[0] = 16'h0005; pool[1] = 16'h0015; pool[2] = 16'h0025;
    pool[3] = 16'h0006; pool[4] = 16'h1006; pool[5] = 16'h0007;
    for (int i = 0; i < 40; i++) begin
      v = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) < 3) do_write(v, 16'($urandom), ($urandom_range(0, 1) == 1));
      else do_read(v);
    end
    chk_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
